// File: rtl/rv32_fetch_pkg.sv
// Shared fetch-stage definitions: canonical NOP encoding, fetch FSM states, PC increment.
`ifndef RV32_INSTR_NOP
`define RV32_INSTR_NOP 32'h0000_0013
`endif

package rv32_fetch_pkg;

    localparam logic [31:0] INSTR_NOP = `RV32_INSTR_NOP;

    typedef enum logic [1:0] {
        FETCH    = 2'd0,
        BUFFERED = 2'd1,
        DRAIN    = 2'd2,
        FAULT    = 2'd3
    } fetch_state_e;

    // Wraps modulo 2^32, so 32'hFFFF_FFFC advances to 0.
    function automatic logic [31:0] pc_next(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/rv32_fetch_buffer.sv
// Single-entry {pc, instr} holding register for a word that arrived while decode was stalled.
module rv32_fetch_buffer
    import rv32_fetch_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic        clear,
    input  logic [31:0] pc_in,
    input  logic [31:0] instr_in,
    output logic [31:0] pc_out,
    output logic [31:0] instr_out
);

    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;

    always_comb begin
        pc_d    = pc_q;
        instr_d = instr_q;
        if (load) begin
            pc_d    = pc_in;
            instr_d = instr_in;
        end else if (clear) begin
            pc_d    = 32'd0;
            instr_d = INSTR_NOP;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q    <= 32'd0;
            instr_q <= INSTR_NOP;
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

    assign pc_out    = pc_q;
    assign instr_out = instr_q;

endmodule

// File: rtl/rv32_fetch.sv
// RV32 instruction fetch stage: PC, bus read handshake, decode-facing output registers.
// Optional misaligned-target fault reporting is enabled by defining RV32_FETCH_MISALIGN_EN.
module rv32_fetch
    import rv32_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall_in,
    input  logic        flush_in,
    input  logic        branch_taken_in,
    input  logic [31:0] branch_pc_in,
    output logic [31:0] instr_address_out,
    output logic        instr_read_out,
    input  logic        instr_ready_in,
    input  logic [31:0] instr_read_value_in,
    output logic        valid_out,
    output logic [31:0] pc_out,
    output logic [31:0] instr_out
`ifdef RV32_FETCH_MISALIGN_EN
    ,
    output logic        instr_misaligned_out
`endif
);

    fetch_state_e state_q, state_d;
    logic [31:0]  fetch_pc_q, fetch_pc_d;
    logic [31:0]  redirect_pc_q, redirect_pc_d;
    logic         valid_q, valid_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  instr_q, instr_d;
    logic [31:0]  target;
    logic         buf_load, buf_clear;
    logic [31:0]  buf_pc, buf_instr;
    logic         deliver;
    logic [31:0]  deliver_pc, deliver_instr;
    logic         jump;
    logic [31:0]  jump_pc;

`ifdef RV32_FETCH_MISALIGN_EN
    logic         fault_pend_q, fault_pend_d;
    logic         mis_q, mis_d;
    logic         deliver_fault;
    assign target = branch_pc_in;
`else
    logic         unused_target_lsbs;
    assign target             = {branch_pc_in[31:2], 2'b00};
    assign unused_target_lsbs = ^branch_pc_in[1:0];
`endif

    rv32_fetch_buffer u_buffer (
        .clk       (clk),
        .reset     (reset),
        .load      (buf_load),
        .clear     (buf_clear),
        .pc_in     (fetch_pc_q),
        .instr_in  (instr_read_value_in),
        .pc_out    (buf_pc),
        .instr_out (buf_instr)
    );

    // Valid/ready: once instr_read_out rises, it and instr_address_out stay put until the
    // cycle instr_ready_in is high; that cycle completes the read and carries the data.
    always_comb begin
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        redirect_pc_d = redirect_pc_q;
        buf_load      = 1'b0;
        buf_clear     = 1'b0;
        deliver       = 1'b0;
        deliver_pc    = fetch_pc_q;
        deliver_instr = instr_read_value_in;
        jump          = 1'b0;
        jump_pc       = target;
`ifdef RV32_FETCH_MISALIGN_EN
        fault_pend_d  = fault_pend_q;
        deliver_fault = 1'b0;
`endif
        case (state_q)
            FETCH: begin
                if (branch_taken_in) begin
                    if (instr_ready_in) begin
                        jump = 1'b1;
                    end else begin
                        redirect_pc_d = target;
                        state_d       = DRAIN;
                    end
                end else if (instr_ready_in) begin
                    fetch_pc_d = pc_next(fetch_pc_q);
                    if (stall_in) begin
                        buf_load = 1'b1;
                        state_d  = BUFFERED;
                    end else begin
                        deliver = 1'b1;
                    end
                end
            end
            BUFFERED: begin
                if (branch_taken_in) begin
                    buf_clear = 1'b1;
                    jump      = 1'b1;
                end else if (!stall_in) begin
                    deliver       = 1'b1;
                    deliver_pc    = buf_pc;
                    deliver_instr = buf_instr;
                    buf_clear     = 1'b1;
                    state_d       = FETCH;
                end
            end
            DRAIN: begin
                // The stale read cannot be withdrawn; the newest redirect wins once it completes.
                if (branch_taken_in) begin
                    redirect_pc_d = target;
                end
                if (instr_ready_in) begin
                    jump    = 1'b1;
                    jump_pc = redirect_pc_d;
                end
            end
`ifdef RV32_FETCH_MISALIGN_EN
            FAULT: begin
                if (branch_taken_in) begin
                    jump = 1'b1;
                end else if (fault_pend_q && !stall_in && !flush_in) begin
                    deliver       = 1'b1;
                    deliver_instr = INSTR_NOP;
                    deliver_fault = 1'b1;
                    fault_pend_d  = 1'b0;
                end
            end
`endif
            default: state_d = FETCH;
        endcase

        if (jump) begin
            fetch_pc_d = jump_pc;
`ifdef RV32_FETCH_MISALIGN_EN
            fault_pend_d = |jump_pc[1:0];
            state_d      = (|jump_pc[1:0]) ? FAULT : FETCH;
`else
            state_d      = FETCH;
`endif
        end
    end

    always_comb begin
        valid_d = valid_q;
        pc_d    = pc_q;
        instr_d = instr_q;
`ifdef RV32_FETCH_MISALIGN_EN
        mis_d   = mis_q;
`endif
        if (branch_taken_in) begin
            valid_d = 1'b0;
`ifdef RV32_FETCH_MISALIGN_EN
            mis_d   = 1'b0;
`endif
        end else if (!stall_in) begin
            valid_d = 1'b0;
`ifdef RV32_FETCH_MISALIGN_EN
            mis_d   = 1'b0;
`endif
            if (flush_in) begin
                instr_d = INSTR_NOP;
            end else if (deliver) begin
                valid_d = 1'b1;
                pc_d    = deliver_pc;
                instr_d = deliver_instr;
`ifdef RV32_FETCH_MISALIGN_EN
                mis_d   = deliver_fault;
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= FETCH;
            fetch_pc_q    <= RESET_VECTOR;
            redirect_pc_q <= 32'd0;
            valid_q       <= 1'b0;
            pc_q          <= 32'd0;
            instr_q       <= INSTR_NOP;
`ifdef RV32_FETCH_MISALIGN_EN
            fault_pend_q  <= 1'b0;
            mis_q         <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            redirect_pc_q <= redirect_pc_d;
            valid_q       <= valid_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
`ifdef RV32_FETCH_MISALIGN_EN
            fault_pend_q  <= fault_pend_d;
            mis_q         <= mis_d;
`endif
        end
    end

    assign instr_read_out    = !reset && (state_q == FETCH || state_q == DRAIN);
    assign instr_address_out = fetch_pc_q;
    assign valid_out         = valid_q;
    assign pc_out            = pc_q;
    assign instr_out         = instr_q;
`ifdef RV32_FETCH_MISALIGN_EN
    assign instr_misaligned_out = mis_q;
`endif

endmodule
